// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver: divider-paced digit rotation, hex decode, active-low outputs.
// Optional leading-zero suppression is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   hex_in,
   input  logic [DIGITS-1:0]     point_in,
   input  logic [DIGITS-1:0]     blank_in,
   input  logic                  le,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     an,
   output logic                  frame_done
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   logic [DIV_W-1:0]     r_div;
   logic [IDX_W-1:0]     r_idx;
   logic [4*DIGITS-1:0]  r_hex;
   logic [DIGITS-1:0]    r_pt;
   logic [DIGITS-1:0]    r_blk;

   logic                 w_tc;
   logic                 w_wrap;
   logic [3:0]           w_nib;
   logic                 w_pt_sel;
   logic                 w_blk_sel;
   logic                 w_lz_sel;
   logic [DIGITS-1:0]    w_an;
   logic [DIGITS-1:0]    w_lzb;

   function automatic logic [6:0] f_decode(input logic [3:0] v);
      case (v)
         4'h0:    f_decode = 7'h3F;
         4'h1:    f_decode = 7'h06;
         4'h2:    f_decode = 7'h5B;
         4'h3:    f_decode = 7'h4F;
         4'h4:    f_decode = 7'h66;
         4'h5:    f_decode = 7'h6D;
         4'h6:    f_decode = 7'h7D;
         4'h7:    f_decode = 7'h07;
         4'h8:    f_decode = 7'h7F;
         4'h9:    f_decode = 7'h6F;
         4'hA:    f_decode = 7'h77;
         4'hB:    f_decode = 7'h7C;
         4'hC:    f_decode = 7'h39;
         4'hD:    f_decode = 7'h5E;
         4'hE:    f_decode = 7'h79;
         default: f_decode = 7'h71;
      endcase
   endfunction

   assign w_tc   = (r_div == DIV_LAST);
   assign w_wrap = w_tc && (r_idx == IDX_LAST);

   // Divider and digit index; frame_done marks the edge on which the index returns to 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div      <= '0;
         r_idx      <= '0;
         frame_done <= 1'b0;
      end else begin
         if (w_tc) begin
            r_div <= '0;
            r_idx <= w_wrap ? '0 : r_idx + IDX_W'(1);
         end else begin
            r_div <= r_div + DIV_W'(1);
         end
         frame_done <= w_wrap;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hex <= '0;
         r_pt  <= '0;
         r_blk <= '0;
      end else if (load) begin
         r_hex <= hex_in;
         r_pt  <= point_in;
         r_blk <= blank_in;
      end
   end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   logic w_run;

   // A digit is suppressed only while every digit from it upward is a zero with no point lit.
   always_comb begin
      w_lzb = '0;
      w_run = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         w_run    = w_run & (r_hex[k*4 +: 4] == 4'h0) & ~r_pt[k];
         w_lzb[k] = w_run;
      end
   end
`else
   assign w_lzb = '0;
`endif

   always_comb begin
      w_nib     = '0;
      w_pt_sel  = 1'b0;
      w_blk_sel = 1'b0;
      w_lz_sel  = 1'b0;
      w_an      = '1;
      for (int k = 0; k < DIGITS; k++) begin
         if (r_idx == IDX_W'(k)) begin
            w_nib     = r_hex[k*4 +: 4];
            w_pt_sel  = r_pt[k];
            w_blk_sel = r_blk[k];
            w_lz_sel  = w_lzb[k];
            w_an[k]   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg <= 7'h7F;
         dp  <= 1'b1;
         an  <= '1;
      end else begin
         an <= w_an;
         if (le || w_blk_sel) begin
            seg <= 7'h7F;
            dp  <= 1'b1;
         end else begin
            dp  <= ~w_pt_sel;
            seg <= w_lz_sel ? 7'h7F : ~f_decode(w_nib);
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized self-checking bench for seg7_scan_driver against an arithmetic scan model,
// run on four parameterizations sharing one stimulus stream.
module tb_seg7_scan_driver;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        load = 1'b0;
   logic [15:0] hex_in = '0;
   logic [3:0]  point_in = '0;
   logic [3:0]  blank_in = '0;
   logic        le = 1'b0;

   logic [6:0]  seg0, seg1, seg2, seg3;
   logic        dp0, dp1, dp2, dp3;
   logic [3:0]  an0, an1;
   logic [0:0]  an2;
   logic [2:0]  an3;
   logic        fd0, fd1, fd2, fd3;
   logic [16:0] o0, o1, o2, o3;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [16:0] RST_O = {7'h7F, 1'b1, 8'hFF, 1'b0};
   localparam logic [16:0] D0_O  = {7'h40, 1'b1, 8'hFE, 1'b0};

   always #5 clk = ~clk;

   seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(3)) u0 (
      .clk(clk), .rst(rst), .load(load), .hex_in(hex_in), .point_in(point_in),
      .blank_in(blank_in), .le(le), .seg(seg0), .dp(dp0), .an(an0), .frame_done(fd0));
   seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(2)) u1 (
      .clk(clk), .rst(rst), .load(load), .hex_in(hex_in), .point_in(point_in),
      .blank_in(blank_in), .le(le), .seg(seg1), .dp(dp1), .an(an1), .frame_done(fd1));
   seg7_scan_driver #(.DIGITS(1), .SCAN_DIV(3)) u2 (
      .clk(clk), .rst(rst), .load(load), .hex_in(hex_in[3:0]), .point_in(point_in[0:0]),
      .blank_in(blank_in[0:0]), .le(le), .seg(seg2), .dp(dp2), .an(an2), .frame_done(fd2));
   seg7_scan_driver #(.DIGITS(3), .SCAN_DIV(1)) u3 (
      .clk(clk), .rst(rst), .load(load), .hex_in(hex_in[11:0]), .point_in(point_in[2:0]),
      .blank_in(blank_in[2:0]), .le(le), .seg(seg3), .dp(dp3), .an(an3), .frame_done(fd3));

   assign o0 = {seg0, dp0, 4'hF, an0, fd0};
   assign o1 = {seg1, dp1, 4'hF, an1, fd1};
   assign o2 = {seg2, dp2, 7'h7F, an2, fd2};
   assign o3 = {seg3, dp3, 5'h1F, an3, fd3};

   function automatic logic [6:0] dec(input logic [3:0] v);
      case (v)
         4'h0: dec = 7'h3F; 4'h1: dec = 7'h06; 4'h2: dec = 7'h5B; 4'h3: dec = 7'h4F;
         4'h4: dec = 7'h66; 4'h5: dec = 7'h6D; 4'h6: dec = 7'h7D; 4'h7: dec = 7'h07;
         4'h8: dec = 7'h7F; 4'h9: dec = 7'h6F; 4'hA: dec = 7'h77; 4'hB: dec = 7'h7C;
         4'hC: dec = 7'h39; 4'hD: dec = 7'h5E; 4'hE: dec = 7'h79; default: dec = 7'h71;
      endcase
   endfunction

   // Outputs after edge number n+1 since reset: digit = floor(n/S) mod D, frame every S*D edges.
   function automatic logic [16:0] calc(input int D, input int S, input int n,
                                        input logic [15:0] hx, input logic [3:0] pt,
                                        input logic [3:0] bl, input logic le_v);
      int k;
      logic [6:0] s;
      logic d;
      logic [7:0] a;
      logic f;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      logic [31:0] hm;
      logic [7:0] pm;
      hm = 32'(hx) & ((32'd1 << (4*D)) - 32'd1);
      pm = 8'(pt) & ((8'd1 << D) - 8'd1);
`endif
      k = (n / S) % D;
      if (le_v || bl[k]) begin
         s = 7'h7F;
         d = 1'b1;
      end else begin
         d = ~pt[k];
         s = ~dec(hx[k*4 +: 4]);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
         if (k > 0 && (hm >> (4*k)) == 32'd0 && (pm >> k) == 8'd0) s = 7'h7F;
`endif
      end
      a = 8'hFF;
      a[k] = 1'b0;
      f = ((n + 1) % (S * D)) == 0;
      return {s, d, a, f};
   endfunction

   int          n;
   logic [15:0] m_hex;
   logic [3:0]  m_pt, m_bl;
   logic [16:0] e0, e1, e2, e3;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         n <= 0;
         m_hex <= '0; m_pt <= '0; m_bl <= '0;
         e0 <= RST_O; e1 <= RST_O; e2 <= RST_O; e3 <= RST_O;
      end else begin
         e0 <= calc(4, 3, n, m_hex, m_pt, m_bl, le);
         e1 <= calc(4, 2, n, m_hex, m_pt, m_bl, le);
         e2 <= calc(1, 3, n, m_hex, m_pt, m_bl, le);
         e3 <= calc(3, 1, n, m_hex, m_pt, m_bl, le);
         n <= n + 1;
         if (load) begin
            m_hex <= hex_in; m_pt <= point_in; m_bl <= blank_in;
         end
      end
   end

   task automatic test_reset();
      #1 rst = 1'b1;
      #2;
      n_vec++; if (o0 !== RST_O) begin n_err++; $display("FAIL reset_u0 got %h want %h", o0, RST_O); end
      n_vec++; if (o3 !== RST_O) begin n_err++; $display("FAIL reset_u3 got %h want %h", o3, RST_O); end
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      n_vec++; if (o0 !== D0_O) begin n_err++; $display("FAIL release_u0 got %h want %h", o0, D0_O); end
      n_vec++; if (o2 !== e2) begin n_err++; $display("FAIL release_u2 got %h want %h", o2, e2); end
      hex_in = 16'h1234; point_in = 4'hF; load = 1'b1;
      @(negedge clk) load = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      n_vec++; if (o0 !== RST_O) begin n_err++; $display("FAIL midreset_u0 got %h want %h", o0, RST_O); end
      n_vec++; if (o1 !== RST_O) begin n_err++; $display("FAIL midreset_u1 got %h want %h", o1, RST_O); end
      @(posedge clk) #1;
      n_vec++; if (o0 !== RST_O) begin n_err++; $display("FAIL reset_hold got %h want %h", o0, RST_O); end
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      n_vec++; if (o0 !== D0_O) begin n_err++; $display("FAIL rerelease_u0 got %h want %h", o0, D0_O); end
      n_vec++; if (an0 !== 4'hE) begin n_err++; $display("FAIL rerelease_an got %h want e", an0); end
   endtask

   task automatic test_decode();
      logic [6:0] want;
      hex_in = 16'h1A7F; point_in = 4'h0; blank_in = 4'h0; le = 1'b0; load = 1'b1;
      @(negedge clk) load = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         n_vec++; if (o0 !== e0) begin n_err++; $display("FAIL decode_u0 cyc %0d got %h want %h", i, o0, e0); end
         n_vec++; if (o1 !== e1) begin n_err++; $display("FAIL decode_u1 cyc %0d got %h want %h", i, o1, e1); end
         case (an1)
            4'hE: want = 7'h0E;
            4'hD: want = 7'h78;
            4'hB: want = 7'h08;
            default: want = 7'h79;
         endcase
         n_vec++; if (seg1 !== want) begin n_err++; $display("FAIL decode_seg an=%h got %h want %h", an1, seg1, want); end
      end
   endtask

   task automatic test_scan_timing();
      int pulses = 0;
      int run = 0;
      bit seen = 1'b0;
      logic [3:0] prev;
      @(negedge clk);
      prev = an0;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         n_vec++; if (o0 !== e0) begin n_err++; $display("FAIL scan_u0 cyc %0d got %h want %h", i, o0, e0); end
         if (fd0) pulses++;
         run++;
         if (an0 !== prev) begin
            n_vec++;
            if (an0 !== {prev[2:0], prev[3]}) begin n_err++; $display("FAIL scan_order got %h want %h", an0, {prev[2:0], prev[3]}); end
            if (seen) begin
               n_vec++;
               if (run != 3) begin n_err++; $display("FAIL scan_hold got %0d want 3", run); end
            end
            seen = 1'b1;
            run = 0;
            prev = an0;
         end
      end
      n_vec++; if (pulses != 2) begin n_err++; $display("FAIL frame_count got %0d want 2", pulses); end
   endtask

   task automatic test_blanking();
      hex_in = 16'($urandom); point_in = 4'($urandom); le = 1'b1; load = 1'b1;
      @(negedge clk) load = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_vec++; if (o0 !== e0) begin n_err++; $display("FAIL le_u0 got %h want %h", o0, e0); end
         n_vec++; if ({seg0, dp0} !== 8'hFF) begin n_err++; $display("FAIL le_blank got %h want ff", {seg0, dp0}); end
      end
      le = 1'b0; hex_in = 16'h1A7F; point_in = 4'h0; blank_in = 4'b0100; load = 1'b1;
      @(negedge clk) load = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         n_vec++; if (o0 !== e0) begin n_err++; $display("FAIL blank_u0 got %h want %h", o0, e0); end
         n_vec++;
         if ((an0 == 4'hB) ? (seg0 !== 7'h7F) : (seg0 === 7'h7F)) begin
            n_err++; $display("FAIL blank_digit an=%h got seg %h", an0, seg0);
         end
      end
      blank_in = 4'h0;
   endtask

   task automatic test_collision();
      bit found = 1'b0;
      hex_in = 16'h0000; point_in = 4'h0; load = 1'b1;
      @(negedge clk) load = 1'b0;
      for (int i = 0; i < 13 && !found; i++) begin
         @(negedge clk);
         if ((n + 1) % 12 == 0) found = 1'b1;
      end
      n_vec++;
      if (!found) begin n_err++; $display("FAIL collision_align got 0 want 1"); end
      hex_in = 16'h0008; load = 1'b1;
      @(negedge clk);
      n_vec++; if (fd0 !== 1'b1) begin n_err++; $display("FAIL collision_fd got %b want 1", fd0); end
      load = 1'b0;
      @(negedge clk);
      n_vec++; if (an0 !== 4'hE) begin n_err++; $display("FAIL collision_an got %h want e", an0); end
      n_vec++; if (seg0 !== 7'h00) begin n_err++; $display("FAIL collision_seg got %h want 00", seg0); end
      n_vec++; if (o0 !== e0) begin n_err++; $display("FAIL collision_u0 got %h want %h", o0, e0); end
   endtask

   task automatic test_lzb();
      logic [6:0] want;
      hex_in = 16'h0050; point_in = 4'h0; blank_in = 4'h0; load = 1'b1;
      @(negedge clk) load = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         n_vec++; if (o0 !== e0) begin n_err++; $display("FAIL lzb_u0 got %h want %h", o0, e0); end
         case (an0)
            4'hE: want = 7'h40;
            4'hD: want = 7'h12;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            default: want = 7'h7F;
`else
            default: want = 7'h40;
`endif
         endcase
         n_vec++; if (seg0 !== want) begin n_err++; $display("FAIL lzb_seg an=%h got %h want %h", an0, seg0, want); end
      end
   endtask

   task automatic test_corner_params();
      int p2 = 0;
      int p3 = 0;
      hex_in = 16'($urandom); point_in = 4'($urandom); load = 1'b1;
      @(negedge clk) load = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         n_vec++; if (o2 !== e2) begin n_err++; $display("FAIL single_u2 got %h want %h", o2, e2); end
         n_vec++; if (o3 !== e3) begin n_err++; $display("FAIL div1_u3 got %h want %h", o3, e3); end
         n_vec++; if (an2 !== 1'b0) begin n_err++; $display("FAIL single_an got %b want 0", an2); end
         if (fd2) p2++;
         if (fd3) p3++;
      end
      n_vec++; if (p2 != 4) begin n_err++; $display("FAIL single_frames got %0d want 4", p2); end
      n_vec++; if (p3 != 4) begin n_err++; $display("FAIL div1_frames got %0d want 4", p3); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         n_vec++; if (o0 !== e0) begin n_err++; $display("FAIL rand_u0 cyc %0d got %h want %h", i, o0, e0); end
         n_vec++; if (o1 !== e1) begin n_err++; $display("FAIL rand_u1 cyc %0d got %h want %h", i, o1, e1); end
         n_vec++; if (o2 !== e2) begin n_err++; $display("FAIL rand_u2 cyc %0d got %h want %h", i, o2, e2); end
         n_vec++; if (o3 !== e3) begin n_err++; $display("FAIL rand_u3 cyc %0d got %h want %h", i, o3, e3); end
         load = ($urandom_range(0, 3) == 0);
         hex_in = 16'($urandom);
         if ($urandom_range(0, 2) == 0) hex_in = hex_in & 16'h00FF;
         point_in = 4'($urandom) & 4'($urandom);
         blank_in = 4'($urandom) & 4'($urandom) & 4'($urandom);
         le = ($urandom_range(0, 15) == 0);
      end
      load = 1'b0;
   endtask

   initial begin
      test_reset();
      test_decode();
      test_scan_timing();
      test_blanking();
      test_collision();
      test_lzb();
      test_corner_params();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
